// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction unit (BTB + gshare PHT).
package bp_pkg;

  localparam int BP_PC_WIDTH_DEF     = 32;
  localparam int BP_BTB_IDX_BITS_DEF = 4;
  localparam int BP_GHR_BITS_DEF     = 4;

  // Tag covers every PC bit above the BTB index and the ignored byte offset.
  function automatic int bp_tag_width(input int pc_w, input int idx_bits);
    return pc_w - idx_bits - 2;
  endfunction

  localparam int BP_TAG_W_DEF = bp_tag_width(BP_PC_WIDTH_DEF, BP_BTB_IDX_BITS_DEF);

  typedef logic [1:0] cnt2_t;

  localparam cnt2_t BP_CNT_RESET = 2'b01;

  typedef struct packed {
    logic                       valid;
    logic [BP_TAG_W_DEF-1:0]    tag;
    logic [BP_PC_WIDTH_DEF-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, next value only; the caller owns the storage.
module sat_counter2
  import bp_pkg::*;
(
  input  cnt2_t cnt_i,
  input  logic  inc_i,
  output cnt2_t cnt_o
);

  // Step towards 3 or 0 and hold at the rail instead of wrapping.
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != 2'b11) begin
        cnt_o = cnt_i + 2'b01;
      end else begin
        cnt_o = cnt_i;
      end
    end else begin
      if (cnt_i != 2'b00) begin
        cnt_o = cnt_i - 2'b01;
      end else begin
        cnt_o = cnt_i;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor: direct-mapped BTB plus gshare PHT, updated from execute.
// Optional performance counters are enabled with `define BP_PERF_CNT_EN.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int BTB_IDX_BITS = BP_BTB_IDX_BITS_DEF,
  parameter int GHR_BITS     = BP_GHR_BITS_DEF,
  parameter int PC_WIDTH     = BP_PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_next_pc,
  output logic [GHR_BITS-1:0] pred_pht_idx,
  input  logic                res_valid,
  input  logic [PC_WIDTH-1:0] res_pc,
  input  logic                res_taken,
  input  logic [PC_WIDTH-1:0] res_target,
  input  logic [GHR_BITS-1:0] res_pht_idx,
  input  logic                res_mispredict,
`ifdef BP_PERF_CNT_EN
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispredicts,
`endif
  output logic [GHR_BITS-1:0] ghr_out
);

  localparam int BTB_ENTRIES = 2 ** BTB_IDX_BITS;
  localparam int PHT_ENTRIES = 2 ** GHR_BITS;
  localparam int TAG_W       = bp_tag_width(PC_WIDTH, BTB_IDX_BITS);

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    btb_target_q [BTB_ENTRIES];
  cnt2_t                  pht_q        [PHT_ENTRIES];
  logic [GHR_BITS-1:0]    ghr_q;
  logic [GHR_BITS-1:0]    ghr_d;

  logic [BTB_IDX_BITS-1:0] fetch_idx_s;
  logic [TAG_W-1:0]        fetch_tag_s;
  logic [GHR_BITS-1:0]     lookup_pht_idx_s;
  logic [PC_WIDTH-1:0]     seq_pc_s;
  logic [BTB_IDX_BITS-1:0] res_idx_s;
  logic [TAG_W-1:0]        res_tag_s;
  cnt2_t                   pht_cur_s;
  cnt2_t                   pht_nxt_s;
  logic                    unused_s;

  // Zero-latency lookup; reads pre-edge state so a same-cycle update is not bypassed.
  always_comb begin
    fetch_idx_s      = fetch_pc[BTB_IDX_BITS+1:2];
    fetch_tag_s      = fetch_pc[PC_WIDTH-1:BTB_IDX_BITS+2];
    lookup_pht_idx_s = fetch_pc[GHR_BITS+1:2] ^ ghr_q;
    seq_pc_s         = fetch_pc + PC_WIDTH'(32'd4);
    pred_hit         = btb_valid_q[fetch_idx_s] && (btb_tag_q[fetch_idx_s] == fetch_tag_s);
    pred_taken       = pred_hit && pht_q[lookup_pht_idx_s][1];
    if (pred_taken) begin
      pred_next_pc = btb_target_q[fetch_idx_s];
    end else begin
      pred_next_pc = seq_pc_s;
    end
  end

  assign pred_pht_idx = lookup_pht_idx_s;
  assign ghr_out      = ghr_q;

  assign res_idx_s = res_pc[BTB_IDX_BITS+1:2];
  assign res_tag_s = res_pc[PC_WIDTH-1:BTB_IDX_BITS+2];
  assign pht_cur_s = pht_q[res_pht_idx];

  sat_counter2 u_pht_cnt (
    .cnt_i (pht_cur_s),
    .inc_i (res_taken),
    .cnt_o (pht_nxt_s)
  );

  // History shifts only on resolved branches, so it is never speculative.
  always_comb begin
    ghr_d = ghr_q;
    if (res_valid) begin
      ghr_d = {ghr_q[GHR_BITS-2:0], res_taken};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Global history register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // PHT counters start weakly not-taken; update uses the index carried from fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= BP_CNT_RESET;
      end
    end else if (res_valid) begin
      pht_q[res_pht_idx] <= pht_nxt_s;
    end
  end

  // BTB valid bits are the only BTB state needing reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid_q <= '0;
    end else if (res_valid && res_taken) begin
      btb_valid_q[res_idx_s] <= 1'b1;
    end
  end

  // Taken branches overwrite the indexed entry, evicting any alias.
  always_ff @(posedge clk) begin
    if (res_valid && res_taken) begin
      btb_tag_q[res_idx_s]    <= res_tag_s;
      btb_target_q[res_idx_s] <= res_target;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches_q;
  logic [31:0] perf_mispredicts_q;

  // Free-running event counters that wrap at 2**32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_branches_q    <= 32'd0;
      perf_mispredicts_q <= 32'd0;
    end else if (res_valid) begin
      perf_branches_q <= perf_branches_q + 32'd1;
      if (res_mispredict) begin
        perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
      end
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
  assign unused_s         = ^res_pc[1:0];
`else
  assign unused_s = ^{res_pc[1:0], res_mispredict};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven, scoreboarded bench for branch_predict_unit (default parameters).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic [3:0]  pred_pht_idx;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic [3:0]  res_pht_idx;
  logic        res_mispredict;
  logic [3:0]  ghr_out;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_pc       (fetch_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .pred_pht_idx   (pred_pht_idx),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .res_pht_idx    (res_pht_idx),
    .res_mispredict (res_mispredict),
`ifdef BP_PERF_CNT_EN
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts),
`endif
    .ghr_out        (ghr_out)
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] nxt;
    logic [3:0]  idx;
    logic [3:0]  ghr;
  } exp_t;

  typedef struct {
    logic        rv;
    logic        rt;
    logic [31:0] rpc;
    logic [31:0] rtgt;
    logic [3:0]  ridx;
    logic [31:0] fpc;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(input logic rv, input logic rt, input logic [31:0] rpc,
                              input logic [31:0] rtgt, input logic [3:0] ridx,
                              input logic [31:0] fpc, input logic hit, input logic taken,
                              input logic [31:0] nxt, input logic [3:0] idx,
                              input logic [3:0] ghr);
    vec_t v;
    v.rv = rv; v.rt = rt; v.rpc = rpc; v.rtgt = rtgt; v.ridx = ridx; v.fpc = fpc;
    v.e.hit = hit; v.e.taken = taken; v.e.nxt = nxt; v.e.idx = idx; v.e.ghr = ghr;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
    end else begin
      e = sb_q.pop_front();
      chk32({tag, ".hit"},   32'(pred_hit),     32'(e.hit));
      chk32({tag, ".taken"}, 32'(pred_taken),   32'(e.taken));
      chk32({tag, ".next"},  pred_next_pc,      e.nxt);
      chk32({tag, ".idx"},   32'(pred_pht_idx), 32'(e.idx));
      chk32({tag, ".ghr"},   32'(ghr_out),      32'(e.ghr));
    end
  endtask

  task automatic drive(input vec_t v);
    res_valid      = v.rv;
    res_taken      = v.rt;
    res_pc         = v.rpc;
    res_target     = v.rtgt;
    res_pht_idx    = v.ridx;
    res_mispredict = 1'b0;
    fetch_pc       = v.fpc;
    sb_q.push_back(v.e);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      compare_out($sformatf("%s[%0d]", tag, i));
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    res_valid = 1'b0;
    res_taken = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rpc, input logic [31:0] rtgt,
                         input logic [3:0] ridx, input logic mis);
    res_valid      = 1'b1;
    res_taken      = rt;
    res_pc         = rpc;
    res_target     = rtgt;
    res_pht_idx    = ridx;
    res_mispredict = mis;
    @(posedge clk);
    #1;
    res_valid      = 1'b0;
    res_mispredict = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bit         sat_t [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    bit         sat_p [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [3:0] sat_g [11] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h1};
    logic [3:0] k;

    reset = 1'b1; res_valid = 1'b0; res_taken = 1'b0; res_pc = 32'h0; res_target = 32'h0;
    res_pht_idx = 4'h0; res_mispredict = 1'b0; fetch_pc = 32'h100;
    do_reset();

    // Reset state, training, idle resolve, pc+4 wrap, ignored low bits.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   32'h0,   4'd0, 32'h100,       1'b0, 1'b0, 32'h104, 4'd0,  4'd0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h100, 32'h200, 4'd3, 32'h100,       1'b1, 1'b0, 32'h104, 4'd1,  4'd1));
    vecs.push_back(mk(1'b1, 1'b1, 32'h100, 32'h200, 4'd3, 32'h100,       1'b1, 1'b1, 32'h200, 4'd3,  4'd3));
    vecs.push_back(mk(1'b0, 1'b1, 32'h100, 32'h999, 4'd3, 32'h100,       1'b1, 1'b1, 32'h200, 4'd3,  4'd3));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   32'h0,   4'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,   4'd12, 4'd3));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   32'h0,   4'd0, 32'h102,       1'b1, 1'b1, 32'h200, 4'd3,  4'd3));
    run_table("basic");

    // Same-cycle update is not visible before the edge.
    drive(mk(1'b1, 1'b1, 32'h100, 32'h280, 4'd3, 32'h100, 1'b1, 1'b1, 32'h200, 4'd3, 4'd3));
    #1;
    compare_out("nobypass.pre");
    e.hit = 1'b1; e.taken = 1'b0; e.nxt = 32'h104; e.idx = 4'd7; e.ghr = 4'd7;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out("nobypass.post");

    // Reset during an update: the update is lost.
    res_valid = 1'b1; res_taken = 1'b1; res_pc = 32'h100; res_target = 32'h300; res_pht_idx = 4'd7;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    res_valid = 1'b0;
    e.hit = 1'b0; e.taken = 1'b0; e.nxt = 32'h104; e.idx = 4'd0; e.ghr = 4'd0;
    sb_q.push_back(e);
    compare_out("rst_mid");

    // Saturation: fill every BTB slot, then walk PHT[3] up to 3 and down to 0.
    for (int i = 0; i < 16; i++) begin
      resolve(1'b1, 32'h400 + 32'(i * 4), 32'h800 + 32'(i * 4), 4'd0, 1'b0);
    end
    for (int i = 0; i < 11; i++) begin
      k = 4'd3 ^ sat_g[i];
      vecs.push_back(mk(1'b1, sat_t[i], 32'h40C, 32'h80C, 4'd3,
                        32'h400 + {26'd0, k, 2'b00}, 1'b1, sat_p[i],
                        sat_p[i] ? 32'h800 + {26'd0, k, 2'b00} : 32'h404 + {26'd0, k, 2'b00},
                        4'd3, sat_g[i]));
    end
    run_table("sat");

    // Aliasing, same-tag target refresh, not-taken leaves BTB alone.
    do_reset();
    vecs.push_back(mk(1'b1, 1'b1, 32'h040, 32'h500, 4'd3, 32'h040, 1'b1, 1'b0, 32'h044, 4'd1,  4'd1));
    vecs.push_back(mk(1'b1, 1'b1, 32'h080, 32'h600, 4'd3, 32'h040, 1'b0, 1'b0, 32'h044, 4'd3,  4'd3));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   32'h0,   4'd0, 32'h080, 1'b1, 1'b1, 32'h600, 4'd3,  4'd3));
    vecs.push_back(mk(1'b1, 1'b1, 32'h080, 32'h640, 4'd7, 32'h080, 1'b1, 1'b1, 32'h640, 4'd7,  4'd7));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0C0, 32'h999, 4'd0, 32'h080, 1'b1, 1'b0, 32'h084, 4'd14, 4'd14));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   32'h0,   4'd0, 32'h0C0, 1'b0, 1'b0, 32'h0C4, 4'd14, 4'd14));
    run_table("alias");

    // History pattern T,N,T,T.
    do_reset();
    vecs.push_back(mk(1'b1, 1'b1, 32'h200, 32'h300, 4'd0, 32'h00C, 1'b0, 1'b0, 32'h010, 4'd2, 4'd1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h200, 32'h300, 4'd0, 32'h00C, 1'b0, 1'b0, 32'h010, 4'd1, 4'd2));
    vecs.push_back(mk(1'b1, 1'b1, 32'h200, 32'h300, 4'd0, 32'h00C, 1'b0, 1'b0, 32'h010, 4'd6, 4'd5));
    vecs.push_back(mk(1'b1, 1'b1, 32'h200, 32'h300, 4'd0, 32'h00C, 1'b0, 1'b0, 32'h010, 4'd8, 4'd11));
    run_table("ghr");

`ifdef BP_PERF_CNT_EN
    do_reset();
    chk32("perf.rst_br", perf_branches, 32'd0);
    chk32("perf.rst_mp", perf_mispredicts, 32'd0);
    for (int i = 0; i < 10; i++) begin
      resolve(1'(i % 2), 32'h100, 32'h200, 4'd0, (i % 3) == 2);
    end
    res_mispredict = 1'b1;
    @(posedge clk);
    #1;
    res_mispredict = 1'b0;
    chk32("perf.br", perf_branches, 32'd10);
    chk32("perf.mp", perf_mispredicts, 32'd3);
    resolve(1'b1, 32'h100, 32'h200, 4'd0, 1'b1);
    res_valid = 1'b1; res_mispredict = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk32("perf.mid_br", perf_branches, 32'd0);
    chk32("perf.mid_mp", perf_mispredicts, 32'd0);
    reset = 1'b0; res_valid = 1'b0; res_mispredict = 1'b0;
`endif

    chk32("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised fetch-stage branch predictor: direct-mapped BTB plus gshare pattern history table (PHT) of 2-bit saturating counters.
- Supersedes the fixed 16-entry BTB / 4-bit global predictor pair in the pipelined ARM datapath.
- Fetch looks up combinationally on PCF; execute stage returns resolved branches for update one clock later.
- The PHT index is carried down the pipeline with the instruction so update hits the same counter used for prediction.

Parameters:
- BTB_IDX_BITS, 4, log2 of BTB entries; tag = pc[31:BTB_IDX_BITS+2].
- GHR_BITS, 4, global history length; PHT has 2**GHR_BITS counters.
- PC_WIDTH, 32, address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- fetch_pc  in  PC_WIDTH  PC being fetched (PCF)
- pred_hit  out  1  BTB valid and tag match
- pred_taken  out  1  pred_hit and PHT counter MSB set
- pred_next_pc  out  PC_WIDTH  BTB target if pred_taken, else fetch_pc+4
- pred_pht_idx  out  GHR_BITS  PHT index used; pipelined to execute by the datapath
- res_valid  in  1  resolved branch in execute this cycle
- res_pc  in  PC_WIDTH  PC of the resolved branch
- res_taken  in  1  actual direction
- res_target  in  PC_WIDTH  actual taken target (ALUResultE)
- res_pht_idx  in  GHR_BITS  pred_pht_idx carried with the branch
- res_mispredict  in  1  direction or target mispredicted (used only by the optional feature)
- ghr_out  out  GHR_BITS  current global history, for debug

Behaviour:
- Lookup is purely combinational, zero latency:
  - btb_idx = fetch_pc[BTB_IDX_BITS+1:2].
  - pht_idx = fetch_pc[GHR_BITS+1:2] XOR ghr.
- Reset (async) drives the following:
  - All BTB valid bits 0 and ghr = 0.
  - All PHT counters = 2'b01 (weakly not-taken).
  - Outputs therefore: pred_hit=0, pred_taken=0, pred_next_pc=fetch_pc+4, pred_pht_idx=fetch_pc[GHR_BITS+1:2].
  - BTB tag/target arrays need no reset.
- Update happens on the rising clk edge when res_valid=1:
  - PHT[res_pht_idx]: increment if res_taken, else decrement. Saturates at 3 and 0; never wraps.
  - ghr <= {ghr[GHR_BITS-2:0], res_taken}. History is non-speculative (resolve order only).
  - If res_taken: BTB[res_pc idx] <= {valid=1, tag of res_pc, res_target}. This overwrites any aliasing entry; a same-tag entry gets its target updated.
  - If not taken: BTB entry untouched.
- res_valid=0: no state changes.
- Same-cycle lookup and update to the same entry or counter: lookup sees the pre-edge (old) value; the new value is visible the next cycle. No bypass.
- pc+4 wraps modulo 2**PC_WIDTH (0xFFFFFFFC -> 0x0).
- fetch_pc[1:0] are ignored.
- Reset asserted mid-update: reset wins, and the update is lost.
- No stall input. The datapath holds fetch_pc stable while stalled, and the outputs follow it.

Optional Feature:
- Macro BP_PERF_CNT_EN.
- Defined: adds outputs perf_branches[31:0] and perf_mispredicts[31:0].
  - Both reset to 0.
  - perf_branches increments on each res_valid.
  - perf_mispredicts increments on res_valid & res_mispredict.
  - Both wrap at 2**32.
- Undefined: ports and counters absent; res_mispredict is unused.

Decomposition:
- Package bp_pkg holds:
  - Constant for counter reset value 2'b01.
  - Typedef btb_entry_t {valid, tag, target}, tag width derived from PC_WIDTH and BTB_IDX_BITS.
  - Typedef cnt2_t.
- One natural sub-module: sat_counter2 (2-bit saturating up/down, combinational next-value), instantiated in the PHT update path.
- BTB and PHT arrays stay inline.

Test Plan:
- Reset, fetch_pc=0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104, ghr_out=0.
- Resolve taken twice: res_pc=0x100, res_target=0x200, res_taken=1, res_pht_idx=lookup idx. Re-fetch 0x100 with matching idx -> pred_hit=1, pred_taken=1, pred_next_pc=0x200.
- Saturation: five taken updates to idx 3, then one not-taken -> counter 3 then 2; pred_taken stays 1. Four further not-taken -> counter 0, no underflow.
- Aliasing, BTB_IDX_BITS=4: taken at 0x040, then taken at 0x080 (same index, different tag) -> fetch 0x040 gives pred_hit=0; fetch 0x080 gives hit with the new target.
- GHR: resolve pattern T,N,T,T -> ghr_out=4'b1011. Fetch 0x00C then gives pred_pht_idx = 4'b0011 ^ 4'b1011 = 4'b1000.
- BP_PERF_CNT_EN: 10 resolves, 3 with res_mispredict=1 -> perf_branches=10, perf_mispredicts=3. Assert reset mid-sequence -> both counters 0.
